hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core: consumes the `ctrl` word, `a_reg` and `b_reg` that `control` emits for the instruction in ID, and tracks in-flight destination registers in EX, MEM and WB. Issues load-use stalls and bubbles, and registers the ALU operand-forwarding selects. Sequences the multi-cycle multiplier: an instruction with `d_sel`=0 occupies EX for MUL_LAT cycles.

## Interface
- MUL_LAT, 4: multiplier occupancy of EX in cycles; legal range 1..15.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction (0 = bubble).
- id_a_reg  in  5  first source register of the ID instruction.
- id_b_reg  in  5  second source register of the ID instruction.
- id_ctrl  in  12  ctrl word of the ID instruction. Bit fields: [11] c_sel, [10] d_sel, [9:8] op_sel, [7] rd_wr, [6] wb_sel, [5] wb_en, [4:0] wb_reg.
- stall  out  1  hold PC and the IF/ID register.
- ex_bubble  out  1  load ID/EX with a NOP this edge.
- ex_hold  out  1  hold ID/EX (multiplier busy).
- fwd_a, fwd_b  out  2 each  registered operand selects for the EX instruction: 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB result.
- mul_busy  out  1  FSM is in MUL.

## Operation
- Tracking entries for EX, MEM and WB, each {valid, wb_en, is_load = wb_sel&wb_en, is_mul = ~d_sel, wb_reg}.
- Advance (RUN, stall=0): EX←ID entry (valid = id_valid), MEM←EX, WB←MEM.
- Matching rule: a source matches an entry iff valid & wb_en & src≠0 & src==wb_reg. Register 0 never matches, so the LW b_reg=0 case needs no special handling.
- Load-use: if the EX entry is_load and matches id_a_reg or id_b_reg while id_valid=1, then stall=1 and ex_bubble=1. On that edge EX←invalid, MEM←EX, WB←MEM, and fwd_a/fwd_b←0.
- Forward select per source, computed in ID and registered on advance:
  - EX entry matches and is not a load → 1.
  - Otherwise MEM entry matches → 2.
  - Otherwise → 0.
  - EX has priority over MEM (newest producer wins).
- A WB-stage producer needs no forwarding; the register file is write-through.
- FSM states:
  - RUN: normal operation.
  - MUL: entered on the advance edge that moves an is_mul instruction into EX, when MUL_LAT>1. Counter loads MUL_LAT-1.
- In MUL:
  - Outputs: stall=1, ex_hold=1, ex_bubble=0, mul_busy=1.
  - Entries: EX entry and fwd_a/fwd_b frozen, MEM←invalid, WB←MEM.
  - Counter decrements; when it reaches 1, next state is RUN.
- MUL_LAT=1: MUL is never entered; the multiplier behaves like the ALU.
- Load-use is evaluated in RUN only. A MULT in ID with a load-use hazard stalls one cycle first, then enters EX.
- A dependent of a MULT is held in ID during MUL. It advances on the RUN cycle in which the MULT leaves EX, with fwd=1.

## Timing
- stall, ex_bubble and ex_hold are combinational from the ID inputs, the EX entry and the FSM state. They have no flop-to-flop latency.
- fwd_a/fwd_b change only on advance edges and are valid for the whole EX residency.
- Reset (asynchronous, active-low, dominates everything, including mid-MUL):
  - State RUN, counter 0, all entries invalid.
  - fwd_a=fwd_b=0 and mul_busy=0.
  - stall, ex_bubble and ex_hold evaluate to 0.
- Occupancy: a MULT latched into EX at edge N gives mul_busy=1 for cycles N..N+MUL_LAT-2. The MULT leaves EX at edge N+MUL_LAT.
- The load-use penalty is exactly one bubble. Back-to-back loads feeding each other each cost one bubble.

## Structure
- Package `pipe_pkg` holds:
  - ctrl bit-index constants (CTRL_D_SEL=10, CTRL_WB_SEL=6, CTRL_WB_EN=5, CTRL_WB_REG_HI/LO=4/0);
  - forward encodings FWD_RF/FWD_EXMEM/FWD_MEMWB;
  - the state enum {RUN, MUL};
  - the tracking-entry struct.
- One sub-module, `mul_sequencer`, contains the MUL_LAT down-counter and the RUN/MUL FSM. Its inputs are start and its output is busy. The hazard compare and forwarding logic stays in `hazard_unit`.

## Test plan
- Reset mid-MUL: assert rst_n=0 during cycle 1 of a MULT → mul_busy, stall and fwd drop to 0 immediately, and all entries are invalid after release.
- ADD r3 then ADD r4,r3,r1 back-to-back → no stall; the second instruction enters EX with fwd_a=1. With one unrelated instruction between them → fwd_a=2. With two between → fwd_a=0.
- LW r5 then SUB r6,r5,r5 → stall=1 and ex_bubble=1 for exactly one cycle, then the SUB enters EX with fwd_a=fwd_b=2.
- Register 0 and precedence:
  - LW r0 then ADD r2,r0,r0 → no stall, fwd 0.
  - ADD writing r7 twice in a row, then a reader of r7 → fwd=1 (newest producer wins).
- MULT r8 (MUL_LAT=4), then AND r9,r8,r2 → mul_busy for 3 cycles, stall for 3 cycles, the MULT stays in EX for 4 cycles, and the AND enters EX with fwd_a=1.
- MUL_LAT=1 build: MULT followed by a dependent ADD → never stalls, fwd_a=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// ctrl word field positions, forward encodings, sequencer states and tracking entries.
package pipe_pkg;

    localparam int CTRL_D_SEL     = 10;
    localparam int CTRL_WB_SEL    = 6;
    localparam int CTRL_WB_EN     = 5;
    localparam int CTRL_WB_REG_HI = 4;
    localparam int CTRL_WB_REG_LO = 0;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } mul_state_t;

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       is_load;
        logic       is_mul;
        logic [4:0] wb_reg;
    } trk_entry_t;

    // r0 is hard-wired zero, so it never creates a dependency.
    function automatic logic src_match(trk_entry_t e, logic [4:0] src);
        return e.valid && e.wb_en && (src != 5'd0) && (src == e.wb_reg);
    endfunction

    function automatic trk_entry_t decode_entry(logic valid, logic [11:0] ctrl);
        trk_entry_t e;
        e.valid   = valid;
        e.wb_en   = ctrl[CTRL_WB_EN];
        e.is_load = ctrl[CTRL_WB_SEL] & ctrl[CTRL_WB_EN];
        e.is_mul  = ~ctrl[CTRL_D_SEL];
        e.wb_reg  = ctrl[CTRL_WB_REG_HI:CTRL_WB_REG_LO];
        return e;
    endfunction

endpackage

// File: rtl/mul_sequencer.sv
// Multiplier occupancy sequencer: holds EX for MUL_LAT cycles after a multiply issues.
//   state | meaning
//   RUN   | pipeline advancing normally, counter idle
//   MUL   | multiply occupying EX, counter counts down to terminal count 1
module mul_sequencer
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    mul_state_t state_q;
    mul_state_t state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                // A single-cycle multiplier never needs to hold EX.
                if (start && (MUL_LAT > 1)) begin
                    state_d = MUL;
                    cnt_d   = CNT_LOAD;
                end
            end
            MUL: begin
                if (cnt_q == 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign busy = (state_q == MUL);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall/bubble, registered operand forwarding
// selects, and EX hold while the multi-cycle multiplier is busy.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_a_reg,
    input  logic [4:0]  id_b_reg,
    input  logic [11:0] id_ctrl,
    output logic        stall,
    output logic        ex_bubble,
    output logic        ex_hold,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mul_busy
);

    trk_entry_t id_ent;
    trk_entry_t ex_q;
    trk_entry_t mem_q;
    trk_entry_t wb_q;
    logic       load_use;
    logic       mul_start;
    logic [1:0] fwd_a_d;
    logic [1:0] fwd_b_d;
    logic       unused_bits;

    // Newest producer wins; a load in EX cannot forward yet, so it falls through to MEM.
    function automatic logic [1:0] fwd_sel(trk_entry_t ex, trk_entry_t mem, logic [4:0] src);
        if (src_match(ex, src) && !ex.is_load) begin
            return FWD_EXMEM;
        end else if (src_match(mem, src)) begin
            return FWD_MEMWB;
        end else begin
            return FWD_RF;
        end
    endfunction

    assign id_ent = decode_entry(id_valid, id_ctrl);

    assign load_use = !mul_busy && id_valid && ex_q.is_load
                      && (src_match(ex_q, id_a_reg) || src_match(ex_q, id_b_reg));

    assign stall     = mul_busy | load_use;
    assign ex_bubble = load_use;
    assign ex_hold   = mul_busy;
    assign mul_start = !stall && id_ent.valid && id_ent.is_mul;

    assign fwd_a_d = fwd_sel(ex_q, mem_q, id_a_reg);
    assign fwd_b_d = fwd_sel(ex_q, mem_q, id_b_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (mul_busy) begin
            mem_q <= '0;
            wb_q  <= mem_q;
        end else if (load_use) begin
            ex_q  <= '0;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else begin
            ex_q  <= id_ent;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            fwd_a <= fwd_a_d;
            fwd_b <= fwd_b_d;
        end
    end

    mul_sequencer #(
        .MUL_LAT(MUL_LAT)
    ) u_mul_seq (
        .clk  (clk),
        .rst_n(rst_n),
        .start(mul_start),
        .busy (mul_busy)
    );

    // WB is tracked for visibility only: the register file is write-through.
    assign unused_bits = ^{id_ctrl[11], id_ctrl[9:7], wb_q,
                           mem_q.is_load, mem_q.is_mul, ex_q.is_mul};

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: a MUL_LAT=4 and a MUL_LAT=1 instance,
// each checked every cycle against a behavioural pipeline model plus directed literals.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  id_valid_r = '0;
    logic [9:0]  id_a_r = '0;
    logic [9:0]  id_b_r = '0;
    logic [23:0] id_ctrl_r = '0;
    logic [1:0]  stall_w;
    logic [1:0]  bubble_w;
    logic [1:0]  hold_w;
    logic [1:0]  busy_w;
    logic [3:0]  fwd_a_w;
    logic [3:0]  fwd_b_w;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid_r[0]),
        .id_a_reg(id_a_r[4:0]), .id_b_reg(id_b_r[4:0]), .id_ctrl(id_ctrl_r[11:0]),
        .stall(stall_w[0]), .ex_bubble(bubble_w[0]), .ex_hold(hold_w[0]),
        .fwd_a(fwd_a_w[1:0]), .fwd_b(fwd_b_w[1:0]), .mul_busy(busy_w[0])
    );

    hazard_unit #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid_r[1]),
        .id_a_reg(id_a_r[9:5]), .id_b_reg(id_b_r[9:5]), .id_ctrl(id_ctrl_r[23:12]),
        .stall(stall_w[1]), .ex_bubble(bubble_w[1]), .ex_hold(hold_w[1]),
        .fwd_a(fwd_a_w[3:2]), .fwd_b(fwd_b_w[3:2]), .mul_busy(busy_w[1])
    );

    typedef struct {
        bit v;
        bit we;
        bit ld;
        bit mul;
        int rd;
    } ent_t;

    typedef struct {
        bit         v;
        logic [4:0] a;
        logic [4:0] b;
        logic [11:0] ctrl;
    } ins_t;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    ent_t m_ex[2];
    ent_t m_mem[2];
    int   m_age[2];
    int   m_fa[2];
    int   m_fb[2];

    function automatic int lat_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic ent_t no_ent();
        ent_t e;
        e.v = 0; e.we = 0; e.ld = 0; e.mul = 0; e.rd = 0;
        return e;
    endfunction

    function automatic int cur_a(int k);
        return int'(id_a_r[k*5 +: 5]);
    endfunction

    function automatic int cur_b(int k);
        return int'(id_b_r[k*5 +: 5]);
    endfunction

    function automatic bit hits(ent_t e, int src);
        return e.v && e.we && (src != 0) && (src == e.rd);
    endfunction

    // A multiply sits in EX for lat cycles; all but its last are busy cycles.
    function automatic bit m_busy(int k);
        return m_ex[k].v && m_ex[k].mul && (m_age[k] < lat_of(k) - 1);
    endfunction

    function automatic bit m_lu(int k);
        return !m_busy(k) && id_valid_r[k] && m_ex[k].ld
               && (hits(m_ex[k], cur_a(k)) || hits(m_ex[k], cur_b(k)));
    endfunction

    function automatic int m_sel(int k, int src);
        if (hits(m_ex[k], src) && !m_ex[k].ld) return 1;
        if (hits(m_mem[k], src)) return 2;
        return 0;
    endfunction

    function automatic ent_t id_ent(int k);
        ent_t e;
        logic [11:0] c;
        c = id_ctrl_r[k*12 +: 12];
        e.v   = id_valid_r[k];
        e.we  = c[5];
        e.ld  = c[5] && c[6];
        e.mul = !c[10];
        e.rd  = int'(c[4:0]);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_ex[k]  = no_ent();
                m_mem[k] = no_ent();
                m_age[k] = 0;
                m_fa[k]  = 0;
                m_fb[k]  = 0;
            end else if (m_busy(k)) begin
                m_age[k] = m_age[k] + 1;
                m_mem[k] = no_ent();
            end else if (m_lu(k)) begin
                m_mem[k] = m_ex[k];
                m_ex[k]  = no_ent();
                m_fa[k]  = 0;
                m_fb[k]  = 0;
            end else begin
                int na;
                int nb;
                na = m_sel(k, cur_a(k));
                nb = m_sel(k, cur_b(k));
                m_mem[k] = m_ex[k];
                m_ex[k]  = id_ent(k);
                m_age[k] = 0;
                m_fa[k]  = na;
                m_fb[k]  = nb;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cyc_stall[%0d]", k), int'(stall_w[k]), int'(m_busy(k) || m_lu(k)));
            chk($sformatf("cyc_bubble[%0d]", k), int'(bubble_w[k]), int'(m_lu(k)));
            chk($sformatf("cyc_hold[%0d]", k), int'(hold_w[k]), int'(m_busy(k)));
            chk($sformatf("cyc_busy[%0d]", k), int'(busy_w[k]), int'(m_busy(k)));
            chk($sformatf("cyc_fwd_a[%0d]", k), int'(fwd_a_w[k*2 +: 2]), m_fa[k]);
            chk($sformatf("cyc_fwd_b[%0d]", k), int'(fwd_b_w[k*2 +: 2]), m_fb[k]);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic ins_t mk(bit dsel, bit wbsel, int rd, int a, int b);
        ins_t i;
        i.v    = 1'b1;
        i.a    = 5'(a);
        i.b    = 5'(b);
        i.ctrl = {1'b0, dsel, 2'b00, 1'b0, wbsel, 1'b1, 5'(rd)};
        return i;
    endfunction

    function automatic ins_t alu(int rd, int a, int b);
        return mk(1'b1, 1'b0, rd, a, b);
    endfunction

    function automatic ins_t lw(int rd, int a);
        return mk(1'b1, 1'b1, rd, a, 0);
    endfunction

    function automatic ins_t mult(int rd, int a, int b);
        return mk(1'b0, 1'b0, rd, a, b);
    endfunction

    function automatic ins_t nop_ins();
        ins_t i;
        i.v = 1'b0; i.a = 5'd0; i.b = 5'd0; i.ctrl = 12'd0;
        return i;
    endfunction

    task automatic drive(int k, ins_t i);
        id_valid_r[k]          = i.v;
        id_a_r[k*5 +: 5]       = i.a;
        id_b_r[k*5 +: 5]       = i.b;
        id_ctrl_r[k*12 +: 12]  = i.ctrl;
    endtask

    ins_t prog[$];
    int   pop_cyc[$];
    int   fa_log[$];
    int   fb_log[$];
    int   n_stall;
    int   n_bub;
    int   n_busy;
    int   n_hold;

    // Front-end emulation: the ID instruction is held while stall is high.
    task automatic run_prog(int k);
        int idx;
        int drain;
        int cyc;
        bit st;
        idx = 0; drain = 0; cyc = 0;
        pop_cyc.delete(); fa_log.delete(); fb_log.delete();
        n_stall = 0; n_bub = 0; n_busy = 0; n_hold = 0;
        while (idx < prog.size() || drain < 6) begin
            if (idx < prog.size()) drive(k, prog[idx]);
            else drive(k, nop_ins());
            @(negedge clk);
            st = stall_w[k];
            n_stall += int'(st);
            n_bub   += int'(bubble_w[k]);
            n_busy  += int'(busy_w[k]);
            n_hold  += int'(hold_w[k]);
            @(posedge clk);
            #1;
            if (idx < prog.size()) begin
                if (!st) begin
                    pop_cyc.push_back(cyc);
                    fa_log.push_back(int'(fwd_a_w[k*2 +: 2]));
                    fb_log.push_back(int'(fwd_b_w[k*2 +: 2]));
                    idx++;
                end
            end else begin
                drain++;
            end
            cyc++;
            if (cyc > 300) begin
                total++;
                bad++;
                $display("FAIL run_timeout: issued %0d of %0d", idx, prog.size());
                break;
            end
        end
        prog.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_stall", int'(stall_w[0]), 0);
        chk("rst_bubble", int'(bubble_w[0]), 0);
        chk("rst_hold", int'(hold_w[0]), 0);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_fwd_a", int'(fwd_a_w[1:0]), 0);
        chk("rst_fwd_b", int'(fwd_b_w[1:0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        prog.push_back(alu(3, 1, 2));
        prog.push_back(alu(4, 3, 1));
        run_prog(0);
        chk("exmem_fwd_a", fa_log[1], 1);
        chk("exmem_fwd_b", fb_log[1], 0);
        chk("exmem_stalls", n_stall, 0);

        prog.push_back(alu(3, 1, 2));
        prog.push_back(alu(10, 1, 2));
        prog.push_back(alu(4, 3, 1));
        run_prog(0);
        chk("memwb_fwd_a", fa_log[2], 2);

        prog.push_back(alu(3, 1, 2));
        prog.push_back(alu(10, 1, 2));
        prog.push_back(alu(11, 1, 2));
        prog.push_back(alu(4, 3, 1));
        run_prog(0);
        chk("wb_fwd_a", fa_log[3], 0);

        prog.push_back(lw(5, 1));
        prog.push_back(alu(6, 5, 5));
        run_prog(0);
        chk("lu_stalls", n_stall, 1);
        chk("lu_bubbles", n_bub, 1);
        chk("lu_fwd_a", fa_log[1], 2);
        chk("lu_fwd_b", fb_log[1], 2);

        prog.push_back(lw(0, 1));
        prog.push_back(alu(2, 0, 0));
        run_prog(0);
        chk("r0_stalls", n_stall, 0);
        chk("r0_fwd_a", fa_log[1], 0);
        chk("r0_fwd_b", fb_log[1], 0);

        prog.push_back(alu(7, 1, 2));
        prog.push_back(alu(7, 1, 2));
        prog.push_back(alu(11, 7, 0));
        run_prog(0);
        chk("newest_fwd_a", fa_log[2], 1);

        prog.push_back(mult(8, 1, 2));
        prog.push_back(alu(9, 8, 2));
        run_prog(0);
        chk("mul_busy_cycles", n_busy, 3);
        chk("mul_hold_cycles", n_hold, 3);
        chk("mul_stall_cycles", n_stall, 3);
        chk("mul_ex_residency", pop_cyc[1] - pop_cyc[0], 4);
        chk("mul_dep_fwd_a", fa_log[1], 1);
        chk("mul_dep_fwd_b", fb_log[1], 0);

        prog.push_back(lw(5, 1));
        prog.push_back(lw(6, 5));
        prog.push_back(alu(12, 6, 0));
        run_prog(0);
        chk("ldld_bubbles", n_bub, 2);
        chk("ldld_fwd_a", fa_log[2], 2);

        prog.push_back(lw(5, 1));
        prog.push_back(mult(8, 5, 0));
        run_prog(0);
        chk("lumul_bubbles", n_bub, 1);
        chk("lumul_stalls", n_stall, 4);
        chk("lumul_fwd_a", fa_log[1], 2);

        prog.push_back(mult(8, 1, 2));
        prog.push_back(alu(9, 8, 2));
        run_prog(1);
        chk("lat1_stalls", n_stall, 0);
        chk("lat1_busy", n_busy, 0);
        chk("lat1_fwd_a", fa_log[1], 1);

        drive(0, alu(8, 1, 2));
        @(posedge clk);
        #1;
        drive(0, mult(12, 8, 0));
        @(posedge clk);
        #1;
        drive(0, nop_ins());
        chk("mr_pre_fwd_a", int'(fwd_a_w[1:0]), 1);
        chk("mr_pre_busy", int'(busy_w[0]), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", int'(busy_w[0]), 0);
        chk("mr_stall", int'(stall_w[0]), 0);
        chk("mr_hold", int'(hold_w[0]), 0);
        chk("mr_fwd_a", int'(fwd_a_w[1:0]), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        drive(0, alu(13, 8, 12));
        #1;
        chk("mr_post_stall", int'(stall_w[0]), 0);
        @(posedge clk);
        #1;
        drive(0, nop_ins());
        chk("mr_post_fwd_a", int'(fwd_a_w[1:0]), 0);
        chk("mr_post_fwd_b", int'(fwd_b_w[1:0]), 0);
        chk("mr_post_busy", int'(busy_w[0]), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
